load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit: the consumer of the decoder's memory controls (`mem_wEn`, `MemSize`, `load_extend_sign`). It takes one access per request from the MEM stage and drives a word-addressed data memory with a req/ack handshake. It aligns store data into byte lanes and extracts and extends load data. While an access is outstanding it stalls the pipeline.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: data width; only 32 is supported.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: MEM stage holds a load or store.
- `req_ready` out 1: the unit accepts a request this cycle.
- `mem_wEn` in 1: active-low. 0 = store, 1 = load.
- `mem_size` in 2: `SIZE_BYTE`=00, `SIZE_HWORD`=01, `SIZE_WORD`=10. 11 = no-op.
- `load_extend_sign` in 1: 1 = sign-extend, 0 = zero-extend.
- `addr` in ADDR_W: byte address (the ALU result).
- `store_data` in 32: rs2 value.
- `rsp_valid` out 1: one-cycle pulse when the access completes.
- `load_data` out 32: extended load result. Valid with `rsp_valid` on a load.
- `misaligned` out 1: qualifies `rsp_valid` (present only with the macro; see Configuration).
- `stall` out 1: high from request accept through the `rsp_valid` cycle, excluding the `rsp_valid` cycle.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out ADDR_W (bits [1:0] = 0), `dmem_be` out 4, `dmem_wdata` out 32: memory request.
- `dmem_ack` in 1, `dmem_rdata` in 32: memory completion.

## Operation
**FSM: IDLE → REQ → RESP → IDLE.**
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: register addr, size, direction, extend and store data.
    - Aligned and `mem_size`≠11 → REQ.
    - `mem_size`=11 → RESP with no memory access.
- **REQ**
  - `dmem_req`=1. All dmem outputs are held stable until `dmem_ack`.
  - On `dmem_ack`: capture `dmem_rdata` → RESP.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle → IDLE.
  - `req_ready`=0, so back-to-back requests are spaced by at least one idle cycle.

**Lane mapping (o = addr[1:0]):**
- Byte: `dmem_be` = 0001<<o; `dmem_wdata` = store_data[7:0] replicated ×4.
- Half: `dmem_be` = o[1] ? 1100 : 0011; `dmem_wdata` = store_data[15:0] replicated ×2.
- Word: `dmem_be` = 1111.
- Loads drive the same `dmem_be`; `dmem_we` = ~mem_wEn.
- Load extraction selects the lane given by o, then sign- or zero-extends to 32 bits. A word load passes through unchanged.

**Boundary rules:**
- `dmem_ack` outside REQ is ignored.
- A no-op size (11) or a store produces `load_data` = 0.

## Timing
- Reset values: state = IDLE; `req_ready`=1; all other outputs 0, including `dmem_be`, `dmem_addr` and `load_data`.
- `dmem_req` rises the cycle after accept.
- Ack in the first REQ cycle gives `rsp_valid` 2 cycles after accept. Each extra wait cycle adds 1.
- Reset asserted mid-access: next cycle IDLE with `dmem_req`=0, and no `rsp_valid` for the aborted access. A late ack is ignored.
- `stall` is combinational from state: (state≠IDLE && state≠RESP) || (IDLE && req_valid).

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no memory request.
  - It goes directly to RESP with `misaligned`=1 alongside `rsp_valid`.
- **Undefined:**
  - The `misaligned` port is tied 0.
  - Offending low address bits are masked: half uses addr[1] only; word uses offset 0. The access proceeds normally.

## Structure
- A shared defines header holds `SIZE_BYTE`/`SIZE_HWORD`/`SIZE_WORD`/`SIZE_NONE` and the FSM state encodings. It sits alongside the existing ALU opcode defines.
- One sub-module, `lsu_lane_align`, is natural: a combinational be/wdata generator plus a load extractor, reused in tests.

## Test plan
- **Byte store:** sb at 0x1003, data 0x000000A5 → `dmem_addr`=0x1000, `be`=1000, `wdata`=0xA5A5A5A5, `we`=1. `rsp_valid` 2 cycles after accept with immediate ack.
- **Sign-extended byte load:** lb at 0x2001, rdata 0x0000_8000 → `load_data`=0xFFFFFF80. The same access as lbu → 0x00000080.
- **Half load with wait states:** lh at 0x3002, ack delayed 3 cycles, rdata 0xBEEF0000 → `load_data`=0xFFFFBEEF. `stall` high 5 cycles; dmem outputs stable throughout.
- **Misaligned word:** lw at 0x4001.
  - With the macro: no `dmem_req`; `rsp_valid`+`misaligned` 1 cycle after accept.
  - Without it: access to 0x4000 with `be`=1111.
- **No-op size:** `mem_size`=11 → no `dmem_req`; `rsp_valid` 1 cycle after accept.
- **Reset mid-access:** reset in REQ → next cycle IDLE, `dmem_req`=0. An ack arriving afterwards produces no `rsp_valid`.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: access sizes, FSM states and lane helpers.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see load_store_unit.sv).
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HWORD = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_NONE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == SIZE_HWORD && off[0])
            || (size == SIZE_WORD && off != 2'b00);
    endfunction

    // Drop the low offset bits a naturally aligned access cannot use.
    function automatic logic [1:0] lane_offset(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            SIZE_HWORD: return {off[1], 1'b0};
            SIZE_WORD:  return 2'b00;
            default:    return off;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane generator for stores and lane extractor/extender for loads.
// Purely combinational; shared by the LSU and its tests.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_sign,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte      = i_rdata[{i_off, 3'b000} +: 8];
        w_half      = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_be        = 4'b0000;
        o_wdata     = 32'h0;
        o_load_data = 32'h0;
        case (i_size)
            SIZE_BYTE: begin
                o_be        = 4'b0001 << i_off;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{i_sign & w_byte[7]}}, w_byte};
            end
            SIZE_HWORD: begin
                o_be        = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = {{16{i_sign & w_half[15]}}, w_half};
            end
            SIZE_WORD: begin
                o_be        = 4'b1111;
                o_wdata     = i_store_data;
                o_load_data = i_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-addressed req/ack data memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of masking.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_mem_wEn,
    input  logic [1:0]        i_mem_size,
    input  logic              i_load_extend_sign,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_misaligned,
    output logic              o_stall,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [DATA_W-1:0] i_dmem_rdata
);

    lsu_state_t          r_state;
    lsu_state_t          w_next;
    logic [ADDR_W-3:0]   r_addr;
    logic [1:0]          r_size;
    logic [1:0]          r_off;
    logic                r_we;
    logic                r_sign;
    logic [DATA_W-1:0]   r_sdata;
    logic [DATA_W-1:0]   r_load_data;
    logic                w_accept;
    logic                w_trap;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_ld;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_mis;

    assign w_trap = is_misaligned(i_mem_size, i_addr[1:0]);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mis <= 1'b0;
        end else if (w_accept) begin
            r_mis <= w_trap;
        end
    end

    assign o_misaligned = r_mis && (r_state == ST_RESP);
`else
    assign w_trap       = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    lsu_lane_align u_align (
        .i_size       (r_size),
        .i_off        (r_off),
        .i_sign       (r_sign),
        .i_store_data (r_sdata),
        .i_rdata      (i_dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_ld)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_next = (i_mem_size == SIZE_NONE || w_trap)
                           ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_dmem_ack) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request fields are frozen at accept so dmem outputs stay stable.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_size      <= SIZE_NONE;
            r_off       <= 2'b00;
            r_we        <= 1'b0;
            r_sign      <= 1'b0;
            r_sdata     <= '0;
            r_load_data <= '0;
        end else if (w_accept) begin
            r_addr      <= i_addr[ADDR_W-1:2];
            r_size      <= i_mem_size;
            r_off       <= lane_offset(i_mem_size, i_addr[1:0]);
            r_we        <= ~i_mem_wEn;
            r_sign      <= i_load_extend_sign;
            r_sdata     <= i_store_data;
            r_load_data <= '0;
        end else if (r_state == ST_REQ && i_dmem_ack) begin
            r_load_data <= r_we ? '0 : w_ld;
        end
    end

    always_comb begin
        o_req_ready  = 1'b0;
        o_rsp_valid  = 1'b0;
        o_stall      = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_be    = 4'b0000;
        o_dmem_wdata = '0;
        unique case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                o_stall     = i_req_valid;
            end
            ST_REQ: begin
                o_stall      = 1'b1;
                o_dmem_req   = 1'b1;
                o_dmem_we    = r_we;
                o_dmem_addr  = {r_addr, 2'b00};
                o_dmem_be    = w_be;
                o_dmem_wdata = w_wdata;
            end
            ST_RESP: o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_load_data = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit.
// Expected values come from an arithmetic model of the access rules.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_wEn = 1'b1;
    logic [1:0]  mem_size = 2'b11;
    logic        ext_sign = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        rsp_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clock            (clk),
        .i_reset            (reset),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_mem_wEn          (mem_wEn),
        .i_mem_size         (mem_size),
        .i_load_extend_sign (ext_sign),
        .i_addr             (addr),
        .i_store_data       (store_data),
        .o_rsp_valid        (rsp_valid),
        .o_load_data        (load_data),
        .o_misaligned       (misaligned),
        .o_stall            (stall),
        .o_dmem_req         (dmem_req),
        .o_dmem_we          (dmem_we),
        .o_dmem_addr        (dmem_addr),
        .o_dmem_be          (dmem_be),
        .o_dmem_wdata       (dmem_wdata),
        .i_dmem_ack         (dmem_ack),
        .i_dmem_rdata       (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access: accept, optional wait states, response, one idle cycle.
    task automatic run_access(input bit st, input logic [1:0] sz,
                              input bit sgn, input logic [31:0] a,
                              input logic [31:0] sd, input int dly,
                              input logic [31:0] rd);
        longint unsigned v;
        int o;
        int oe;
        int stalls;
        bit mis;
        bit skip;
        logic [31:0] e_be;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
        o   = int'(a % 4);
        mis = (sz == 2'b01 && (o % 2) == 1) || (sz == 2'b10 && o != 0);
        skip = (sz == 2'b11) || (TRAP && mis);
        oe  = (sz == 2'b00) ? o : (sz == 2'b01) ? (o / 2) * 2 : 0;
        e_be = (sz == 2'b00) ? (32'd1 << oe)
             : (sz == 2'b01) ? (32'd3 << oe) : 32'd15;
        e_wd = (sz == 2'b00) ? sd[7:0] * 32'h01010101
             : (sz == 2'b01) ? sd[15:0] * 32'h00010001 : sd;
        v = 0;
        if (sz == 2'b00) begin
            v = (rd >> (8 * oe)) % 256;
            if (sgn && v >= 128) v = v + 64'hFFFFFF00;
        end else if (sz == 2'b01) begin
            v = (rd >> (8 * oe)) % 65536;
            if (sgn && v >= 32768) v = v + 64'hFFFF0000;
        end else if (sz == 2'b10) begin
            v = rd;
        end
        e_ld = (st || skip) ? 32'h0 : v[31:0];

        @(negedge clk);
        req_valid  = 1'b1;
        mem_wEn    = ~st;
        mem_size   = sz;
        ext_sign   = sgn;
        addr       = a;
        store_data = sd;
        #1;
        check("accept_ready", req_ready, 1);
        check("accept_stall", stall, 1);
        stalls = 1;
        @(negedge clk);
        req_valid  = 1'b0;
        addr       = $urandom;
        store_data = $urandom;
        mem_size   = 2'($urandom);
        mem_wEn    = 1'($urandom);
        if (skip) begin
            dmem_ack = 1'($urandom);
            #1;
            check("skip_rsp", rsp_valid, 1);
            check("skip_req", dmem_req, 0);
            check("skip_mis", misaligned, TRAP && mis);
            check("skip_ld", load_data, 0);
            check("skip_stall", stall, 0);
        end else begin
            for (int w = 0; w <= dly; w++) begin
                if (w > 0) @(negedge clk);
                dmem_ack   = (w == dly);
                dmem_rdata = (w == dly) ? rd : 32'($urandom);
                #1;
                check("req_valid", dmem_req, 1);
                check("req_addr", dmem_addr, a & ~32'd3);
                check("req_be", {28'h0, dmem_be}, e_be);
                check("req_we", dmem_we, st);
                if (st) check("req_wdata", dmem_wdata, e_wd);
                check("req_rsp", rsp_valid, 0);
                stalls += int'(stall);
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            #1;
            check("rsp_valid", rsp_valid, 1);
            check("rsp_ld", load_data, e_ld);
            check("rsp_mis", misaligned, 0);
            check("rsp_stall", stall, 0);
            check("rsp_ready", req_ready, 0);
            check("rsp_req", dmem_req, 0);
            check("stall_cycles", 32'(stalls), 32'(dly + 2));
        end
        @(negedge clk);
        dmem_ack = 1'($urandom);
        #1;
        check("idle_ready", req_ready, 1);
        check("idle_rsp", rsp_valid, 0);
        check("idle_req", dmem_req, 0);
        dmem_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_rsp", rsp_valid, 0);
        check("rst_req", dmem_req, 0);
        check("rst_be", {28'h0, dmem_be}, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_ld", load_data, 0);
        check("rst_stall", stall, 0);
        check("rst_mis", misaligned, 0);
        reset = 1'b0;

        run_access(1, 2'b00, 0, 32'h1003, 32'h000000A5, 0, 32'h0);
        run_access(0, 2'b00, 1, 32'h2001, 32'h0, 0, 32'h00008000);
        run_access(0, 2'b00, 0, 32'h2001, 32'h0, 0, 32'h00008000);
        run_access(0, 2'b01, 1, 32'h3002, 32'h0, 3, 32'hBEEF0000);
        run_access(0, 2'b10, 0, 32'h4001, 32'h0, 0, 32'h12345678);
        run_access(1, 2'b11, 0, 32'h5000, 32'hFFFFFFFF, 0, 32'h0);
        run_access(0, 2'b01, 0, 32'h6003, 32'h0, 1, 32'h8001C002);

        // Abort an access with reset while it waits for the memory.
        @(negedge clk);
        req_valid = 1'b1;
        mem_wEn   = 1'b1;
        mem_size  = 2'b10;
        addr      = 32'h7000;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("abort_req", dmem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        dmem_ack = 1'b1;
        #1;
        check("abort_idle_req", dmem_req, 0);
        check("abort_ready", req_ready, 1);
        check("abort_rsp0", rsp_valid, 0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        check("abort_rsp1", rsp_valid, 0);
        check("abort_req1", dmem_req, 0);

        for (int i = 0; i < 300; i++) begin
            run_access(1'($urandom), 2'($urandom), 1'($urandom),
                       $urandom, $urandom, int'($urandom_range(0, 4)),
                       $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
